// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store unit over a word-addressed memory
// Optional statistics counters are built when LSU_STATS_EN is defined.
module load_store_unit #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_writeData,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_readdata,
  output logic [31:0]   stat_loads,
  output logic [31:0]   stat_stores,
  output logic [31:0]   stat_errors
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [1:0]    size_q;
  logic          write_q, signed_q, err_q;
  logic [DW-1:0] wdata_q, word_q;

  logic          req_err, accept;
  logic [DW-1:0] merged_word, load_data;
  logic [7:0]    load_byte;
  logic [15:0]   load_half;

  assign req_err = (req_size == 2'b11)
                 | ((req_size == SZ_HALF) & req_addr[0])
                 | ((req_size == SZ_WORD) & (|req_addr[1:0]));
  assign accept  = req_valid & req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      word_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= req_addr;
        size_q   <= req_size;
        write_q  <= req_write;
        signed_q <= req_signed;
        err_q    <= req_err;
        wdata_q  <= req_wdata;
      end
      if (state_q == RD) begin
        word_q <= mem_readdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                      state_d = RESP;
          else if (!req_write)              state_d = RD;
          else if (req_size == SZ_WORD)     state_d = WR;
          else                              state_d = RD;
        end
      end
      RD:      state_d = write_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sub-word stores splice the new lanes into the word fetched during RD.
  always_comb begin
    merged_word = word_q;
    case (size_q)
      SZ_BYTE: merged_word[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      SZ_HALF: merged_word[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
      default: merged_word = wdata_q;
    endcase
  end

  always_comb begin
    load_byte = word_q[{addr_q[1:0], 3'b000} +: 8];
    load_half = word_q[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      SZ_BYTE: load_data = signed_q ? {{24{load_byte[7]}}, load_byte} : {24'h0, load_byte};
      SZ_HALF: load_data = signed_q ? {{16{load_half[15]}}, load_half} : {16'h0, load_half};
      default: load_data = word_q;
    endcase
  end

  // Memory strobes are gated by rst so a reset landing on WR never commits a write.
  assign req_ready     = (state_q == IDLE);
  assign mem_read      = (state_q == RD) & ~rst;
  assign mem_write     = (state_q == WR) & ~rst;
  assign mem_address   = {addr_q[AW-1:2], 2'b00};
  assign mem_writeData = mem_write ? merged_word : '0;
  assign resp_valid    = (state_q == RESP) & ~rst;
  assign resp_err      = resp_valid & err_q;
  assign resp_rdata    = (resp_valid & ~err_q & ~write_q) ? load_data : '0;

`ifdef LSU_STATS_EN
  logic [31:0] loads_q, stores_q, errors_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      loads_q  <= '0;
      stores_q <= '0;
      errors_q <= '0;
    end else if (state_q == RESP) begin
      if (err_q)        errors_q <= errors_q + 32'd1;
      else if (write_q) stores_q <= stores_q + 32'd1;
      else              loads_q  <= loads_q + 32'd1;
    end
  end

  assign stat_loads  = loads_q;
  assign stat_stores = stores_q;
  assign stat_errors = errors_q;
`else
  assign stat_loads  = 32'h0;
  assign stat_stores = 32'h0;
  assign stat_errors = 32'h0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address, mem_writeData, mem_readdata;
  logic        mem_read, mem_write;
  logic [31:0] stat_loads, stat_stores, stat_errors;

  logic [31:0] mem [0:15];

  int n_checks = 0;
  int n_err    = 0;

  int          o_lat, o_reads, o_writes;
  logic [31:0] o_wd, o_waddr, o_raddr, o_rdata;
  logic        o_err, o_rdy_bad, o_extra;

  always #5 clk = ~clk;

  assign mem_readdata = mem[mem_address[5:2]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_address[5:2]] <= mem_writeData;
  end

  load_store_unit #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_read(mem_read), .mem_write(mem_write), .mem_readdata(mem_readdata),
    .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errors(stat_errors)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request, then scrambles req_* to prove the DUT latched them.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0;
    req_size = 2'b10; req_signed = ~sg; req_write = ~w;
    o_lat = 0; o_reads = 0; o_writes = 0; o_wd = 0; o_waddr = 0; o_raddr = 0;
    o_rdata = 32'hX; o_err = 1'bX; o_rdy_bad = 1'b0; o_extra = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (mem_read) begin o_reads++; o_raddr = mem_address; end
      if (mem_write) begin o_writes++; o_wd = mem_writeData; o_waddr = mem_address; end
      if (req_ready) o_rdy_bad = 1'b1;
      if (resp_valid) begin
        o_lat = k; o_rdata = resp_rdata; o_err = resp_err;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (resp_valid || !req_ready) o_extra = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; req_valid = 1'b0;

    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check("rst_mem_rw", {30'h0, mem_read, mem_write}, 32'h0);
    check("rst_mem_wdata", mem_writeData, 32'h0);
    check("rst_mem_addr", mem_address, 32'h0);
    check("rst_stats", stat_loads | stat_stores | stat_errors, 32'h0);
    @(posedge clk); #1;
    check("no_accept_in_rst", {31'h0, mem_read}, 32'h0);

    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    check("wst_lat", o_lat, 2);
    check("wst_writes", o_writes, 1);
    check("wst_reads", o_reads, 0);
    check("wst_addr", o_waddr, 32'h10);
    check("wst_data", o_wd, 32'hDEADBEEF);
    check("wst_rdata", o_rdata, 32'h0);
    check("wst_err", {31'h0, o_err}, 32'h0);
    check("wst_ready_busy", {31'h0, o_rdy_bad}, 32'h0);
    check("wst_single_pulse", {31'h0, o_extra}, 32'h0);
    check("wst_mem", mem[4], 32'hDEADBEEF);

    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB);
    check("wst2_mem", mem[4], 32'h8899AABB);

    run_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    check("lb_s_lat", o_lat, 2);
    check("lb_s_reads", o_reads, 1);
    check("lb_s_writes", o_writes, 0);
    check("lb_s_raddr", o_raddr, 32'h10);
    check("lb_s_rdata", o_rdata, 32'hFFFFFF88);
    check("lb_s_err", {31'h0, o_err}, 32'h0);

    run_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    check("lb_u_rdata", o_rdata, 32'h00000088);

    run_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    check("lh_s_rdata", o_rdata, 32'hFFFFAABB);

    run_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234CAFE);
    check("sh_lat", o_lat, 3);
    check("sh_reads", o_reads, 1);
    check("sh_writes", o_writes, 1);
    check("sh_data", o_wd, 32'hCAFEAABB);
    check("sh_ready_busy", {31'h0, o_rdy_bad}, 32'h0);
    check("sh_mem", mem[4], 32'hCAFEAABB);

    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lw_rdata", o_rdata, 32'hCAFEAABB);
    run_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    check("lh_u_hi_rdata", o_rdata, 32'h0000CAFE);
    run_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    check("lb_s_lane1", o_rdata, 32'hFFFFFFAA);

    run_req(1'b0, 2'b10, 1'b0, 32'h11, 32'h0);
    check("mis_lat", o_lat, 1);
    check("mis_err", {31'h0, o_err}, 32'h1);
    check("mis_rdata", o_rdata, 32'h0);
    check("mis_mem_rw", o_reads + o_writes, 0);

    run_req(1'b1, 2'b11, 1'b0, 32'h20, 32'h12345678);
    check("rsv_lat", o_lat, 1);
    check("rsv_err", {31'h0, o_err}, 32'h1);
    check("rsv_rdata", o_rdata, 32'h0);
    check("rsv_mem_rw", o_reads + o_writes, 0);

`ifdef LSU_STATS_EN
    check("stat_loads", stat_loads, 32'd6);
    check("stat_stores", stat_stores, 32'd3);
    check("stat_errors", stat_errors, 32'd2);
`else
    check("stat_loads", stat_loads, 32'd0);
    check("stat_stores", stat_stores, 32'd0);
    check("stat_errors", stat_errors, 32'd0);
`endif

    // Byte store interrupted by reset during its WR cycle.
    req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h55; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rstwr_rd", {31'h0, mem_read}, 32'h1);
    @(posedge clk); #1;
    check("rstwr_wr_before", {31'h0, mem_write}, 32'h1);
    rst = 1'b1;
    #1;
    check("rstwr_wr_gated", {31'h0, mem_write}, 32'h0);
    check("rstwr_wdata_gated", mem_writeData, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstwr_mem", mem[4], 32'hCAFEAABB);
    check("rstwr_ready", {31'h0, req_ready}, 32'h1);
    o_extra = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (resp_valid || mem_write) o_extra = 1'b1;
      @(posedge clk); #1;
    end
    check("rstwr_no_resp", {31'h0, o_extra}, 32'h0);
    check("rstwr_stats_clr", stat_loads | stat_stores | stat_errors, 32'h0);

    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("post_rst_lw", o_rdata, 32'hCAFEAABB);
    check("post_rst_lat", o_lat, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
